// File: rtl/artillery_pkg.sv
// Shared types, player constants and width helpers for the artillery engine.
package artillery_pkg;

    typedef enum logic [1:0] {
        ST_AIM    = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_IMPACT = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // Bits needed to index n distinct values, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level; clr_i forgets the history.
module btn_edge (
    input  logic clk,
    input  logic nrst,
    input  logic clr_i,
    input  logic btn_i,
    output logic rise_c
);

    logic prev_q;
    logic prev_d;

    // Next history value: cleared on request so a held button can re-trigger.
    always_comb begin
        prev_d = btn_i;
        if (clr_i) begin
            prev_d = 1'b0;
        end
    end

    // Previous-level register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_c = btn_i & ~prev_q;

endmodule

// File: rtl/artillery_game_core.sv
// Two-player turn-based artillery engine: aiming, cell-by-cell shell flight,
// impact scoring and game over with restart.
// Optional wind input enabled by defining ARTILLERY_WIND_EN.
module artillery_game_core
    import artillery_pkg::*;
#(
    parameter int unsigned FIELD_W       = 8,
    parameter int unsigned ZONE          = 3,
    parameter int unsigned MAX_LIFE      = 3,
    parameter int unsigned PWR_W         = 2,
    parameter int unsigned MIN_RANGE     = 2,
    parameter int unsigned STEP_CYCLES   = 4,
    parameter int unsigned IMPACT_CYCLES = 8
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic                                 btn_up,
    input  logic                                 btn_dn,
    input  logic                                 btn_fire,
    input  logic                                 btn_restart,
    input  logic [PWR_W-1:0]                     power,
`ifdef ARTILLERY_WIND_EN
    input  logic signed [2:0]                    wind,
`endif
    output logic [width_of(FIELD_W)-1:0]         pos1,
    output logic [width_of(FIELD_W)-1:0]         pos2,
    output logic [width_of(MAX_LIFE+1)-1:0]      life1,
    output logic [width_of(MAX_LIFE+1)-1:0]      life2,
    output logic                                 turn,
    output logic                                 shell_valid,
    output logic [width_of(FIELD_W)-1:0]         shell_pos,
    output logic [FIELD_W-1:0]                   shell_onehot,
    output logic                                 hit,
    output logic                                 game_over,
    output logic                                 winner
);

    localparam int unsigned POS_W  = width_of(FIELD_W);
    localparam int unsigned LIFE_W = width_of(MAX_LIFE + 1);
    localparam int unsigned CALC_W = POS_W + PWR_W + 1;
    localparam int unsigned CNT_W  = width_of(max_u(STEP_CYCLES, IMPACT_CYCLES));

    localparam logic [POS_W-1:0]  P1_MIN    = POS_W'(FIELD_W - ZONE);
    localparam logic [POS_W-1:0]  P1_MAX    = POS_W'(FIELD_W - 1);
    localparam logic [POS_W-1:0]  P2_MIN    = POS_W'(0);
    localparam logic [POS_W-1:0]  P2_MAX    = POS_W'(ZONE - 1);
    localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(MAX_LIFE);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  IMP_LAST  = CNT_W'(IMPACT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [POS_W-1:0]    pos1_q, pos1_d, pos2_q, pos2_d;
    logic [LIFE_W-1:0]   life1_q, life1_d, life2_q, life2_d;
    logic                turn_q, turn_d;
    logic                shell_valid_q, shell_valid_d;
    logic [POS_W-1:0]    shell_pos_q, shell_pos_d;
    logic [FIELD_W-1:0]  shell_onehot_q, shell_onehot_d;
    logic                hit_q, hit_d;
    logic                game_over_q, game_over_d;
    logic                winner_q, winner_d;
    logic [POS_W-1:0]    landing_q, landing_d;
    logic                off_field_q, off_field_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic up_p, dn_p, fire_p, restart_p;
    logic restart_c;

    logic [CALC_W-1:0]   dist_raw_c;
    logic [CALC_W-1:0]   dist_c;
    logic [CALC_W-1:0]   sum_c;
    logic [POS_W-1:0]    land_c;
    logic                off_c;

    assign restart_c = (state_q == ST_OVER) && restart_p;

    btn_edge u_edge_up      (.clk(clk), .nrst(nrst), .clr_i(restart_c), .btn_i(btn_up),      .rise_c(up_p));
    btn_edge u_edge_dn      (.clk(clk), .nrst(nrst), .clr_i(restart_c), .btn_i(btn_dn),      .rise_c(dn_p));
    btn_edge u_edge_fire    (.clk(clk), .nrst(nrst), .clr_i(restart_c), .btn_i(btn_fire),    .rise_c(fire_p));
    btn_edge u_edge_restart (.clk(clk), .nrst(nrst), .clr_i(restart_c), .btn_i(btn_restart), .rise_c(restart_p));

`ifdef ARTILLERY_WIND_EN
    logic signed [CALC_W:0] wind_ext_c;
    logic signed [CALC_W:0] eff_s_c;
`endif

    // Shot range and landing cell for the active tank, clamped at the field edges.
    always_comb begin
        dist_raw_c = CALC_W'(MIN_RANGE) + CALC_W'(power);
        dist_c     = dist_raw_c;
`ifdef ARTILLERY_WIND_EN
        wind_ext_c = {{(CALC_W - 2){wind[2]}}, wind};
        if (turn_q == P1) begin
            eff_s_c = $signed({1'b0, dist_raw_c}) - wind_ext_c;
        end else begin
            eff_s_c = $signed({1'b0, dist_raw_c}) + wind_ext_c;
        end
        if (eff_s_c < $signed((CALC_W + 1)'(1))) begin
            dist_c = CALC_W'(1);
        end else begin
            dist_c = eff_s_c[CALC_W-1:0];
        end
`endif
        sum_c  = CALC_W'(pos2_q) + dist_c;
        land_c = '0;
        off_c  = 1'b0;
        if (turn_q == P1) begin
            if (dist_c > CALC_W'(pos1_q)) begin
                off_c = 1'b1;
            end else begin
                land_c = POS_W'(CALC_W'(pos1_q) - dist_c);
            end
        end else begin
            if (sum_c > CALC_W'(FIELD_W - 1)) begin
                land_c = P1_MAX;
                off_c  = 1'b1;
            end else begin
                land_c = POS_W'(sum_c);
            end
        end
    end

    // Game FSM next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        pos1_d        = pos1_q;
        pos2_d        = pos2_q;
        life1_d       = life1_q;
        life2_d       = life2_q;
        turn_d        = turn_q;
        shell_valid_d = shell_valid_q;
        shell_pos_d   = shell_pos_q;
        hit_d         = 1'b0;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        landing_d     = landing_q;
        off_field_d   = off_field_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_AIM: begin
                if (fire_p) begin
                    landing_d     = land_c;
                    off_field_d   = off_c;
                    shell_valid_d = 1'b1;
                    shell_pos_d   = (turn_q == P1) ? pos1_q - POS_W'(1) : pos2_q + POS_W'(1);
                    cnt_d         = '0;
                    state_d       = ST_FLIGHT;
                end else if (up_p != dn_p) begin
                    if (turn_q == P1) begin
                        if (up_p && (pos1_q != P1_MAX)) pos1_d = pos1_q + POS_W'(1);
                        if (dn_p && (pos1_q != P1_MIN)) pos1_d = pos1_q - POS_W'(1);
                    end else begin
                        if (up_p && (pos2_q != P2_MAX)) pos2_d = pos2_q + POS_W'(1);
                        if (dn_p && (pos2_q != P2_MIN)) pos2_d = pos2_q - POS_W'(1);
                    end
                end
            end
            ST_FLIGHT: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    if (shell_pos_q == landing_q) begin
                        shell_valid_d = 1'b0;
                        shell_pos_d   = '0;
                        state_d       = ST_IMPACT;
                        if (turn_q == P1) begin
                            if (!off_field_q && (landing_q == pos2_q)) begin
                                hit_d = 1'b1;
                                if (life2_q != '0) life2_d = life2_q - LIFE_W'(1);
                            end
                        end else begin
                            if (!off_field_q && (landing_q == pos1_q)) begin
                                hit_d = 1'b1;
                                if (life1_q != '0) life1_d = life1_q - LIFE_W'(1);
                            end
                        end
                    end else begin
                        shell_pos_d = (turn_q == P1) ? shell_pos_q - POS_W'(1) : shell_pos_q + POS_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IMPACT: begin
                if (cnt_q == IMP_LAST) begin
                    cnt_d = '0;
                    if (((turn_q == P1) ? life2_q : life1_q) == '0) begin
                        game_over_d = 1'b1;
                        winner_d    = turn_q;
                        state_d     = ST_OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = ST_AIM;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OVER: begin
                if (restart_p) begin
                    state_d       = ST_AIM;
                    pos1_d        = P1_MIN;
                    pos2_d        = P2_MAX;
                    life1_d       = LIFE_INIT;
                    life2_d       = LIFE_INIT;
                    turn_d        = P1;
                    shell_valid_d = 1'b0;
                    shell_pos_d   = '0;
                    game_over_d   = 1'b0;
                    winner_d      = 1'b0;
                    landing_d     = '0;
                    off_field_d   = 1'b0;
                    cnt_d         = '0;
                end
            end
            default: state_d = ST_AIM;
        endcase

        shell_onehot_d = shell_valid_d ? (FIELD_W'(1) << shell_pos_d) : '0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= ST_AIM;
            pos1_q         <= P1_MIN;
            pos2_q         <= P2_MAX;
            life1_q        <= LIFE_INIT;
            life2_q        <= LIFE_INIT;
            turn_q         <= P1;
            shell_valid_q  <= 1'b0;
            shell_pos_q    <= '0;
            shell_onehot_q <= '0;
            hit_q          <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
            landing_q      <= '0;
            off_field_q    <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            pos1_q         <= pos1_d;
            pos2_q         <= pos2_d;
            life1_q        <= life1_d;
            life2_q        <= life2_d;
            turn_q         <= turn_d;
            shell_valid_q  <= shell_valid_d;
            shell_pos_q    <= shell_pos_d;
            shell_onehot_q <= shell_onehot_d;
            hit_q          <= hit_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            landing_q      <= landing_d;
            off_field_q    <= off_field_d;
            cnt_q          <= cnt_d;
        end
    end

    assign pos1         = pos1_q;
    assign pos2         = pos2_q;
    assign life1        = life1_q;
    assign life2        = life2_q;
    assign turn         = turn_q;
    assign shell_valid  = shell_valid_q;
    assign shell_pos    = shell_pos_q;
    assign shell_onehot = shell_onehot_q;
    assign hit          = hit_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_artillery_game_core.sv
// Self-checking bench for artillery_game_core: shell trajectories are
// scoreboarded cycle by cycle; scenario tasks check hits, lives, turns and reset.
module tb_artillery_game_core;

    localparam int unsigned FIELD_W       = 8;
    localparam int unsigned ZONE          = 3;
    localparam int unsigned MAX_LIFE      = 3;
    localparam int unsigned PWR_W         = 3;
    localparam int unsigned MIN_RANGE     = 2;
    localparam int unsigned STEP_CYCLES   = 4;
    localparam int unsigned IMPACT_CYCLES = 8;

    logic             clk;
    logic             nrst;
    logic             btn_up, btn_dn, btn_fire, btn_restart;
    logic [PWR_W-1:0] power;
`ifdef ARTILLERY_WIND_EN
    logic signed [2:0] wind;
`endif
    logic [2:0]         pos1, pos2, shell_pos;
    logic [1:0]         life1, life2;
    logic               turn, shell_valid, hit, game_over, winner;
    logic [FIELD_W-1:0] shell_onehot;

    int n_tests = 0;
    int n_fails = 0;
    int exp_q[$];

    artillery_game_core #(
        .FIELD_W(FIELD_W), .ZONE(ZONE), .MAX_LIFE(MAX_LIFE), .PWR_W(PWR_W),
        .MIN_RANGE(MIN_RANGE), .STEP_CYCLES(STEP_CYCLES), .IMPACT_CYCLES(IMPACT_CYCLES)
    ) dut (
        .clk(clk), .nrst(nrst),
        .btn_up(btn_up), .btn_dn(btn_dn), .btn_fire(btn_fire), .btn_restart(btn_restart),
        .power(power),
`ifdef ARTILLERY_WIND_EN
        .wind(wind),
`endif
        .pos1(pos1), .pos2(pos2), .life1(life1), .life2(life2), .turn(turn),
        .shell_valid(shell_valid), .shell_pos(shell_pos), .shell_onehot(shell_onehot),
        .hit(hit), .game_over(game_over), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0 up, 1 dn, 2 fire, 3 restart, 4 up+dn, 5 fire+up
    task automatic press(input int which);
        btn_up = 0; btn_dn = 0; btn_fire = 0; btn_restart = 0;
        tick();
        case (which)
            0: btn_up = 1;
            1: btn_dn = 1;
            2: btn_fire = 1;
            3: btn_restart = 1;
            4: begin btn_up = 1; btn_dn = 1; end
            default: begin btn_fire = 1; btn_up = 1; end
        endcase
        tick();
        btn_up = 0; btn_dn = 0; btn_fire = 0; btn_restart = 0;
    endtask

    task automatic push_path(input int from, input int to);
        int c = from;
        forever begin
            repeat (STEP_CYCLES) exp_q.push_back(c);
            if (c == to) break;
            c = (to > from) ? c + 1 : c - 1;
        end
    endtask

    // Drains the trajectory scoreboard; returns on the first IMPACT cycle.
    task automatic track_flight(input bit poke);
        int cyc = 0;
        int idx = 0;
        bit seen = 0;
        int e;
        logic [FIELD_W-1:0] oh;
        while (cyc < 400) begin
            if (shell_valid) begin
                seen = 1;
                if (poke) begin
                    if (idx == 2) begin btn_up = 1; btn_fire = 1; end
                    if (idx == 3) begin btn_up = 0; btn_fire = 0; end
                    if (idx == 5) btn_dn = 1;
                    if (idx == 6) btn_dn = 0;
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL sb_extra: shell_pos=%0d still valid, want no more cells", shell_pos);
                end else begin
                    e = exp_q.pop_front();
                    if (shell_pos !== 3'(e)) begin
                        n_fails++;
                        $display("FAIL sb_shell_pos[%0d]: got %0d want %0d", idx, shell_pos, e);
                    end
                    oh = '0;
                    oh[e] = 1'b1;
                    n_tests++;
                    if (shell_onehot !== oh) begin
                        n_fails++;
                        $display("FAIL sb_onehot[%0d]: got %b want %b", idx, shell_onehot, oh);
                    end
                end
                idx++;
            end else if (seen) begin
                break;
            end
            tick();
            cyc++;
        end
        n_tests++;
        if (!seen || cyc >= 400) begin
            n_fails++;
            $display("FAIL flight_timeout: seen=%0d cycles=%0d, want flight ending within 400", seen, cyc);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL sb_missing: %0d expected cells not seen, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        nrst = 0; btn_up = 0; btn_dn = 0; btn_fire = 0; btn_restart = 0; power = '0;
`ifdef ARTILLERY_WIND_EN
        wind = 3'sd0;
`endif
        #22;
        n_tests++; if (pos1 !== 3'd5) begin n_fails++; $display("FAIL rst_pos1: got %0d want 5", pos1); end
        n_tests++; if (pos2 !== 3'd2) begin n_fails++; $display("FAIL rst_pos2: got %0d want 2", pos2); end
        n_tests++; if (life1 !== 2'd3 || life2 !== 2'd3) begin n_fails++; $display("FAIL rst_life: got %0d/%0d want 3/3", life1, life2); end
        n_tests++; if ({turn, shell_valid, hit, game_over, winner} !== 5'b0) begin n_fails++;
            $display("FAIL rst_flags: got %b want 00000", {turn, shell_valid, hit, game_over, winner}); end
        n_tests++; if (shell_pos !== 3'd0 || shell_onehot !== '0) begin n_fails++;
            $display("FAIL rst_shell: got %0d/%b want 0/0", shell_pos, shell_onehot); end
        tick();
        nrst = 1;
        tick();
    endtask

    task automatic p2_miss();
        power = 3'd0;
        push_path(3, 4);
        press(2);
        track_flight(0);
        n_tests++; if (hit !== 1'b0) begin n_fails++; $display("FAIL p2_miss_hit: got %0d want 0", hit); end
        n_tests++; if (life1 !== 2'd3) begin n_fails++; $display("FAIL p2_miss_life1: got %0d want 3", life1); end
        repeat (IMPACT_CYCLES) tick();
        n_tests++; if (turn !== 1'b0) begin n_fails++; $display("FAIL p2_miss_turn: got %0d want 0", turn); end
    endtask

    task automatic test_hit();
        power = 3'd1;
        push_path(4, 2);
        press(2);
        track_flight(0);
        n_tests++; if (hit !== 1'b1) begin n_fails++; $display("FAIL hit_pulse: got %0d want 1", hit); end
        n_tests++; if (life2 !== 2'd2) begin n_fails++; $display("FAIL hit_life2: got %0d want 2", life2); end
        n_tests++; if (life1 !== 2'd3) begin n_fails++; $display("FAIL hit_life1: got %0d want 3", life1); end
        tick();
        n_tests++; if (hit !== 1'b0) begin n_fails++; $display("FAIL hit_one_cycle: got %0d want 0", hit); end
        repeat (IMPACT_CYCLES - 2) tick();
        n_tests++; if (turn !== 1'b0) begin n_fails++; $display("FAIL hit_turn_early: got %0d want 0", turn); end
        tick();
        n_tests++; if (turn !== 1'b1) begin n_fails++; $display("FAIL hit_turn: got %0d want 1", turn); end
    endtask

    task automatic test_miss();
        p2_miss();
        power = 3'd3;
        push_path(4, 0);
        press(2);
        track_flight(0);
        n_tests++; if (hit !== 1'b0) begin n_fails++; $display("FAIL miss_hit: got %0d want 0", hit); end
        n_tests++; if (life2 !== 2'd2) begin n_fails++; $display("FAIL miss_life2: got %0d want 2", life2); end
        repeat (IMPACT_CYCLES) tick();
        n_tests++; if (turn !== 1'b1) begin n_fails++; $display("FAIL miss_turn: got %0d want 1", turn); end
        p2_miss();
    endtask

    task automatic test_move();
        int exp_up[3] = '{6, 7, 7};
        press(1);
        n_tests++; if (pos1 !== 3'd5) begin n_fails++; $display("FAIL move_dn_sat: got %0d want 5", pos1); end
        for (int i = 0; i < 3; i++) begin
            press(0);
            n_tests++; if (pos1 !== 3'(exp_up[i])) begin n_fails++; $display("FAIL move_up[%0d]: got %0d want %0d", i, pos1, exp_up[i]); end
        end
        press(4);
        n_tests++; if (pos1 !== 3'd7) begin n_fails++; $display("FAIL move_both: got %0d want 7", pos1); end
        tick();
        btn_dn = 1;
        repeat (20) tick();
        btn_dn = 0;
        n_tests++; if (pos1 !== 3'd6) begin n_fails++; $display("FAIL move_held: got %0d want 6", pos1); end
        press(1);
        n_tests++; if (pos1 !== 3'd5 || pos2 !== 3'd2) begin n_fails++; $display("FAIL move_final: got %0d/%0d want 5/2", pos1, pos2); end
    endtask

    task automatic test_offfield();
        power = 3'd7;
        push_path(4, 0);
        press(2);
        track_flight(0);
        n_tests++; if (hit !== 1'b0) begin n_fails++; $display("FAIL off_hit: got %0d want 0", hit); end
        n_tests++; if (life2 !== 2'd2) begin n_fails++; $display("FAIL off_life2: got %0d want 2", life2); end
        repeat (IMPACT_CYCLES) tick();
        n_tests++; if (turn !== 1'b1) begin n_fails++; $display("FAIL off_turn: got %0d want 1", turn); end
        p2_miss();
    endtask

    task automatic test_fire_priority();
        power = 3'd1;
        push_path(4, 2);
        press(5);
        n_tests++; if (pos1 !== 3'd5 || shell_valid !== 1'b1) begin n_fails++;
            $display("FAIL fire_up: got pos1=%0d valid=%0d want 5/1", pos1, shell_valid); end
        track_flight(1);
        n_tests++; if (pos1 !== 3'd5) begin n_fails++; $display("FAIL flight_btn_pos1: got %0d want 5", pos1); end
        n_tests++; if (hit !== 1'b1 || life2 !== 2'd1) begin n_fails++;
            $display("FAIL fire_up_hit: got hit=%0d life2=%0d want 1/1", hit, life2); end
        repeat (IMPACT_CYCLES) tick();
        n_tests++; if (turn !== 1'b1) begin n_fails++; $display("FAIL fire_up_turn: got %0d want 1", turn); end
        p2_miss();
    endtask

    task automatic test_game_over();
        power = 3'd1;
        push_path(4, 2);
        press(2);
        track_flight(0);
        n_tests++; if (hit !== 1'b1 || life2 !== 2'd0) begin n_fails++;
            $display("FAIL go_hit: got hit=%0d life2=%0d want 1/0", hit, life2); end
        repeat (IMPACT_CYCLES) tick();
        n_tests++; if (game_over !== 1'b1 || winner !== 1'b0 || turn !== 1'b0) begin n_fails++;
            $display("FAIL go_flags: got go=%0d win=%0d turn=%0d want 1/0/0", game_over, winner, turn); end
        press(2);
        tick();
        n_tests++; if (shell_valid !== 1'b0 || game_over !== 1'b1) begin n_fails++;
            $display("FAIL go_fire_ignored: got valid=%0d go=%0d want 0/1", shell_valid, game_over); end
        press(1);
        n_tests++; if (pos1 !== 3'd5) begin n_fails++; $display("FAIL go_move_ignored: got %0d want 5", pos1); end
        press(3);
        n_tests++; if (pos1 !== 3'd5 || pos2 !== 3'd2 || life1 !== 2'd3 || life2 !== 2'd3) begin n_fails++;
            $display("FAIL restart_vals: got %0d/%0d/%0d/%0d want 5/2/3/3", pos1, pos2, life1, life2); end
        n_tests++; if ({turn, shell_valid, hit, game_over, winner} !== 5'b0) begin n_fails++;
            $display("FAIL restart_flags: got %b want 00000", {turn, shell_valid, hit, game_over, winner}); end
        press(0);
        n_tests++; if (pos1 !== 3'd6) begin n_fails++; $display("FAIL restart_aim: got %0d want 6", pos1); end
        press(1);
    endtask

`ifdef ARTILLERY_WIND_EN
    task automatic test_wind();
        wind = 3'sd1;
        power = 3'd2;
        push_path(4, 2);
        press(2);
        track_flight(0);
        wind = 3'sd0;
        n_tests++; if (hit !== 1'b1 || life2 !== 2'd2) begin n_fails++;
            $display("FAIL wind_hit: got hit=%0d life2=%0d want 1/2", hit, life2); end
    endtask
`endif

    task automatic test_reset_midflight();
        power = 3'd1;
        press(2);
        repeat (5) tick();
        n_tests++; if (shell_valid !== 1'b1) begin n_fails++; $display("FAIL mid_inflight: got %0d want 1", shell_valid); end
        #1;
        nrst = 0;
        #1;
        n_tests++; if (shell_valid !== 1'b0 || shell_pos !== 3'd0 || shell_onehot !== '0) begin n_fails++;
            $display("FAIL mid_shell: got %0d/%0d/%b want 0/0/0", shell_valid, shell_pos, shell_onehot); end
        n_tests++; if (pos1 !== 3'd5 || pos2 !== 3'd2 || life1 !== 2'd3 || life2 !== 2'd3 || turn !== 1'b0) begin n_fails++;
            $display("FAIL mid_vals: got %0d/%0d/%0d/%0d/%0d want 5/2/3/3/0", pos1, pos2, life1, life2, turn); end
        tick();
        nrst = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_move();
        test_offfield();
        test_fire_priority();
        test_game_over();
`ifdef ARTILLERY_WIND_EN
        test_wind();
`endif
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/artillery_game_core.md
Name: artillery_game_core

Overview:
- Parametrised two-player turn-based artillery engine: FSM, tank positions, lives, and a shell that steps one cell at a time across a FIELD_W-cell field.
- Sits between the button debouncers/power encoder and the 7-segment display mapper.
- Adds over the previous generation:
  - configurable field size, zone size, lives and power width;
  - animated cell-by-cell flight;
  - edge-detected buttons;
  - off-field misses;
  - explicit game-over with restart.

Parameters:
- FIELD_W, 8: number of cells; index 0 is player-2 edge, FIELD_W-1 is player-1 edge.
- ZONE, 3: cells each tank may occupy. Constraint: 2*ZONE <= FIELD_W.
- MAX_LIFE, 3: starting lives per tank, >=1.
- PWR_W, 2: width of the power input.
- MIN_RANGE, 2: distance at power 0, >=1.
- STEP_CYCLES, 4: clocks the shell spends in each cell, >=1.
- IMPACT_CYCLES, 8: clocks spent in IMPACT, >=1.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- btn_up  in  1  debounced level; move active tank toward higher index
- btn_dn  in  1  debounced level; move active tank toward lower index
- btn_fire  in  1  debounced level; fire
- btn_restart  in  1  debounced level; restart after game over
- power  in  PWR_W  shot power, sampled at fire
- pos1  out  clog2(FIELD_W)  player-1 cell
- pos2  out  clog2(FIELD_W)  player-2 cell
- life1  out  clog2(MAX_LIFE+1)  player-1 lives
- life2  out  clog2(MAX_LIFE+1)  player-2 lives
- turn  out  1  0 = player 1 active, 1 = player 2 active
- shell_valid  out  1  shell in flight
- shell_pos  out  clog2(FIELD_W)  shell cell, 0 when not valid
- shell_onehot  out  FIELD_W  one-hot of shell_pos, all zero when not valid
- hit  out  1  one-cycle pulse on a successful hit
- game_over  out  1  game finished
- winner  out  1  0 = player 1 won, 1 = player 2 won; valid only while game_over

Behaviour:
- Clock/reset: all flops on clk rising edge, cleared asynchronously by nrst low, including mid-flight.
- Reset values:
  - pos1 = FIELD_W-ZONE, pos2 = ZONE-1.
  - life1 = life2 = MAX_LIFE.
  - turn = 0, shell_valid = 0, shell_pos = 0, hit = 0, game_over = 0, winner = 0.
  - state = AIM, edge-detector history = 0.
- Buttons: each is rising-edge detected internally (registered previous level); a held button acts once.
- States: AIM, FLIGHT, IMPACT, OVER.
- AIM:
  - Up/dn pulse moves the active tank one cell, saturating at its zone limits: player 1 in [FIELD_W-ZONE, FIELD_W-1], player 2 in [0, ZONE-1].
  - Up and dn in the same cycle: no move.
  - Fire pulse: fire wins over any same-cycle move, which is dropped.
- Fire handling (in AIM):
  - dist = MIN_RANGE + power.
  - Player 1: landing = pos1 - dist; if dist > pos1, landing = 0 and off_field = 1.
  - Player 2: landing = pos2 + dist; if it exceeds FIELD_W-1, landing = FIELD_W-1 and off_field = 1.
  - Compute in clog2(FIELD_W)+PWR_W+1 bits.
  - Latch landing/off_field and go to FLIGHT.
- FLIGHT:
  - First cycle: shell_valid = 1, shell_pos = launcher ∓ 1 (toward the opponent).
  - Shell holds each cell STEP_CYCLES clocks, then advances one cell.
  - After STEP_CYCLES clocks at landing, go to IMPACT.
  - Passing over the target cell en route is not a hit.
- IMPACT:
  - Entry cycle: shell_valid = 0.
  - If !off_field and landing == opponent position: hit = 1 for that cycle and opponent life decrements on that edge.
  - After IMPACT_CYCLES clocks: if opponent life == 0, go to OVER with game_over = 1 and winner = shooter; otherwise toggle turn and go to AIM.
- Buttons are ignored during FLIGHT and IMPACT.
- OVER: all buttons except restart ignored; a restart pulse restores all reset values synchronously. Restart is ignored in other states.
- Lives never underflow.

Optional Feature:
- Macro: ARTILLERY_WIND_EN.
- When defined:
  - Adds port wind, in, 3-bit signed, sampled at fire; positive values push toward higher index.
  - Effective distance = dist - wind for player 1, dist + wind for player 2, floored at 1.
  - Landing/off-field rules then apply unchanged.
- When undefined: no wind port and no wind logic.

Decomposition:
- Package artillery_pkg holds:
  - state enum (AIM, FLIGHT, IMPACT, OVER);
  - player constants P1 = 0, P2 = 1;
  - width helper functions.
- Sub-module btn_edge: one rising-edge detector with clk/nrst, instantiated four times.

Test Plan:
Defaults (FIELD_W 8, ZONE 3, MAX_LIFE 3, PWR_W 2, MIN_RANGE 2, STEP_CYCLES 4, IMPACT_CYCLES 8).
- Hit: reset; power = 1; fire -> shell_pos 4,3,2, 4 clocks each; hit pulse 1 cycle; life2 3->2; after 8 clocks turn = 1, state AIM.
- Miss and boundary: turn 0, power = 3 -> landing 0, no hit, turn toggles. Player 1 btn_dn at pos 5 -> stays 5; btn_up x3 -> 6, 7, 7. Button held 20 clocks -> one move only.
- Off-field (PWR_W = 3): pos1 = 5, power = 7 -> shell visits cells 4..0, no hit, life2 unchanged.
- Fire plus up in the same cycle -> pos1 unchanged, flight starts. Buttons pressed during FLIGHT -> no effect.
- Game over: three player-1 hits, with player-2 misses between -> life2 = 0, game_over = 1, winner = 0, fire ignored; restart -> all reset values.
- nrst asserted mid-FLIGHT -> shell_valid = 0 and reset values immediately without a clock. With ARTILLERY_WIND_EN, wind = +1, player 1 power 2 -> landing 2, hit.
